// File: rtl/round_key_sequencer_if.sv
// Bus bundle between the AES-128 round-key sequencer, the key-expansion stage and the round datapath.
// The sequencer side uses modport master; the environment side uses modport slave.
interface round_key_sequencer_if #(
  parameter int KEY_W = 128
);
  // Key loading.
  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic             key_ready;
  logic             rk_restart;

  // Expansion-stage link.
  logic [KEY_W-1:0] exp_key_out;
  logic [3:0]       exp_count;
  logic             exp_first_round;
  logic [KEY_W-1:0] exp_key_in;

  // Handshake: a round key transfers on every rising edge where rk_valid && rk_ready.
  // While rk_valid is high and rk_ready is low, rk_out and rk_round are held stable.
  // rk_valid never drops without a transfer, except on reset.
  logic [KEY_W-1:0] rk_out;
  logic [3:0]       rk_round;
  logic             rk_valid;
  logic             rk_ready;
  logic             seq_done;

  modport master (
    input  key_in, key_load, rk_restart, exp_key_in, rk_ready,
    output key_ready, exp_key_out, exp_count, exp_first_round,
           rk_out, rk_round, rk_valid, seq_done
  );

  modport slave (
    output key_in, key_load, rk_restart, exp_key_in, rk_ready,
    input  key_ready, exp_key_out, exp_count, exp_first_round,
           rk_out, rk_round, rk_valid, seq_done
  );
endinterface

// File: rtl/round_key_sequencer.sv
// Sequences AES-128 round keys 0..10 through the key-expansion stage and presents them over valid/ready.
// Optional macro ROUND_KEY_CACHE_EN adds an 11-entry round-key cache so that a restart replays at one key per cycle.
module round_key_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic                         clk,
  input  logic                         reset_n,
  round_key_sequencer_if.master        bus,
  output logic [2:0]                   state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VALID  = 3'd1,
    ST_GEN    = 3'd2,
    ST_CAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_REPLAY = 3'd5
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] cipher_key_q, cipher_key_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic [KEY_W-1:0] rk_out_q, rk_out_d;
  logic [3:0]       rk_round_q, rk_round_d;
  logic             rk_valid_q, rk_valid_d;
  logic             seq_done_q, seq_done_d;
  logic             handshake;

`ifdef ROUND_KEY_CACHE_EN
  logic [KEY_W-1:0] cache_q [0:NUM_ROUNDS];
  logic             cache_we;
  logic [3:0]       cache_waddr;
  logic [KEY_W-1:0] cache_wdata;
`endif

  assign handshake = rk_valid_q && bus.rk_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cipher_key_q <= '0;
      cur_key_q    <= '0;
      rk_out_q     <= '0;
      rk_round_q   <= '0;
      rk_valid_q   <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cipher_key_q <= cipher_key_d;
      cur_key_q    <= cur_key_d;
      rk_out_q     <= rk_out_d;
      rk_round_q   <= rk_round_d;
      rk_valid_q   <= rk_valid_d;
      seq_done_q   <= seq_done_d;
    end
  end

`ifdef ROUND_KEY_CACHE_EN
  // Storage only; DONE is reachable solely after all entries of the current key were written.
  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_q[cache_waddr] <= cache_wdata;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cipher_key_d = cipher_key_q;
    cur_key_d    = cur_key_q;
    rk_out_d     = rk_out_q;
    rk_round_d   = rk_round_q;
    rk_valid_d   = rk_valid_q;
    seq_done_d   = 1'b0;
`ifdef ROUND_KEY_CACHE_EN
    cache_we     = 1'b0;
    cache_waddr  = '0;
    cache_wdata  = '0;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.key_load) begin
          cipher_key_d = bus.key_in;
          cur_key_d    = bus.key_in;
          rk_out_d     = bus.key_in;
          rk_round_d   = '0;
          rk_valid_d   = 1'b1;
          state_d      = ST_VALID;
`ifdef ROUND_KEY_CACHE_EN
          cache_we     = 1'b1;
          cache_waddr  = '0;
          cache_wdata  = bus.key_in;
`endif
        end else if (bus.rk_restart && (state_q == ST_DONE)) begin
          cur_key_d  = cipher_key_q;
          rk_round_d = '0;
          rk_valid_d = 1'b1;
`ifdef ROUND_KEY_CACHE_EN
          rk_out_d   = cache_q[0];
          state_d    = ST_REPLAY;
`else
          rk_out_d   = cipher_key_q;
          state_d    = ST_VALID;
`endif
        end
      end

      ST_VALID: begin
        if (handshake) begin
          rk_valid_d = 1'b0;
          if (rk_round_q == LAST_ROUND) begin
            seq_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            rk_round_d = rk_round_q + 4'd1;
            state_d    = ST_GEN;
          end
        end
      end

      // The expansion stage registers its g-function this cycle from the stable cur_key/exp_count.
      ST_GEN: begin
        state_d = ST_CAP;
      end

      ST_CAP: begin
        cur_key_d  = bus.exp_key_in;
        rk_out_d   = bus.exp_key_in;
        rk_valid_d = 1'b1;
        state_d    = ST_VALID;
`ifdef ROUND_KEY_CACHE_EN
        cache_we    = 1'b1;
        cache_waddr = rk_round_q;
        cache_wdata = bus.exp_key_in;
`endif
      end

`ifdef ROUND_KEY_CACHE_EN
      ST_REPLAY: begin
        if (handshake) begin
          if (rk_round_q == LAST_ROUND) begin
            rk_valid_d = 1'b0;
            seq_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            rk_round_d = rk_round_q + 4'd1;
            rk_out_d   = cache_q[rk_round_q + 4'd1];
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.key_ready       = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.exp_key_out     = cur_key_q;
  assign bus.exp_count       = rk_round_q - 4'd1;
  assign bus.exp_first_round = (state_q == ST_IDLE);
  assign bus.rk_out          = rk_out_q;
  assign bus.rk_round        = rk_round_q;
  assign bus.rk_valid        = rk_valid_q;
  assign bus.seq_done        = seq_done_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: FIPS-197 key schedule table, stall, ignored load, mid-run reset, restart and load/restart priority.
module tb_round_key_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] state_dbg;

  round_key_sequencer_if bus ();

  round_key_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- expansion-stage model (AES-128 key schedule step) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (a != 8'h00 && gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] cnt);
    logic [31:0] w0, w1, w2, w3, rw, t, n0, n1, n2, n3;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(cnt)) rc = xtime(rc);
    end
    {w0, w1, w2, w3} = k;
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox(rw[31:24]) ^ rc, sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  assign bus.exp_key_in = next_key(bus.exp_key_out, bus.exp_count);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    int           cyc;
  } vec_t;

  vec_t vecs [11];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_X = 128'hdeadbeefcafef00d0123456789abcdef;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (bus.rk_valid !== 1'b1 && k < 8) begin
      step();
      k++;
    end
    if (bus.rk_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL rk_valid_timeout: rk_valid=%b expected 1 (cycle %0d)", bus.rk_valid, cycle);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key_in   = k;
    bus.key_load = 1'b1;
    cycle        = 0;
    step();
    bus.key_load = 1'b0;
  endtask

  function automatic int replay_cyc(input int r);
`ifdef ROUND_KEY_CACHE_EN
    return 1 + r;
`else
    return 1 + 3 * r;
`endif
  endfunction

  // mode: 0 no timing check, 1 load cadence, 2 restart cadence
  task automatic run_rounds(input int last, input int mode, input int stall_r, input int ldpulse_r);
    for (int i = 0; i <= last; i++) begin
      wait_valid();
      if (mode == 1) chk($sformatf("valid_cycle_r%0d", i), 128'(cycle), 128'(vecs[i].cyc));
      if (mode == 2) chk($sformatf("replay_cycle_r%0d", i), 128'(cycle), 128'(replay_cyc(i)));
      chk($sformatf("rk_round_r%0d", i), 128'(bus.rk_round), 128'(vecs[i].rnd));
      chk($sformatf("rk_out_r%0d", i), bus.rk_out, vecs[i].key);
      if (i == stall_r) begin
        bus.rk_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk("stall_valid", 128'(bus.rk_valid), 128'(1));
          chk("stall_round", 128'(bus.rk_round), 128'(vecs[i].rnd));
          chk("stall_rk_out", bus.rk_out, vecs[i].key);
          chk("stall_exp_key_out", bus.exp_key_out, vecs[i].key);
        end
        bus.rk_ready = 1'b1;
      end
      if (i == ldpulse_r) begin
        bus.key_in   = KEY_X;
        bus.key_load = 1'b1;
        chk("key_ready_busy", 128'(bus.key_ready), 128'(0));
        step();
        bus.key_load = 1'b0;
        chk("load_ignored_state", 128'(state_dbg), 128'(2));
        chk("load_ignored_exp_count", 128'(bus.exp_count), 128'(i));
      end else begin
        step();
      end
    end
    if (last == 10) begin
      chk("seq_done_pulse", 128'(bus.seq_done), 128'(1));
      chk("done_key_ready", 128'(bus.key_ready), 128'(1));
      chk("done_valid_low", 128'(bus.rk_valid), 128'(0));
      step();
      chk("seq_done_single", 128'(bus.seq_done), 128'(0));
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1};
    vecs[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 4};
    vecs[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 7};
    vecs[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 10};
    vecs[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 13};
    vecs[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 16};
    vecs[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 19};
    vecs[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 22};
    vecs[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 25};
    vecs[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 28};
    vecs[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 31};

    // clock/reset
    reset_n        = 1'b0;
    bus.key_in     = '0;
    bus.key_load   = 1'b0;
    bus.rk_restart = 1'b0;
    bus.rk_ready   = 1'b1;
    repeat (3) step();
    chk("reset_valid", 128'(bus.rk_valid), 128'(0));
    chk("reset_key_ready", 128'(bus.key_ready), 128'(1));
    chk("reset_rk_out", bus.rk_out, 128'h0);
    chk("reset_rk_round", 128'(bus.rk_round), 128'(0));
    chk("reset_seq_done", 128'(bus.seq_done), 128'(0));
    chk("reset_exp_key_out", bus.exp_key_out, 128'h0);
    chk("reset_first_round", 128'(bus.exp_first_round), 128'(1));
    reset_n = 1'b1;
    step();

    // restart in IDLE is ignored
    bus.rk_restart = 1'b1;
    step();
    bus.rk_restart = 1'b0;
    chk("idle_restart_ignored", 128'(bus.rk_valid), 128'(0));

    // full pass, rk_ready tied high
    load_key(KEY_A);
    chk("first_round_low", 128'(bus.exp_first_round), 128'(0));
    run_rounds(10, 1, -1, -1);

    // stall on round 3, ignored load during round 5
    load_key(KEY_A);
    run_rounds(10, 0, 3, 5);

    // reset while in CAP of round 7
    load_key(KEY_A);
    run_rounds(6, 1, -1, -1);
    chk("gen_state_r7", 128'(state_dbg), 128'(2));
    chk("gen_exp_count_r7", 128'(bus.exp_count), 128'(6));
    step();
    chk("cap_state_r7", 128'(state_dbg), 128'(3));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midreset_valid", 128'(bus.rk_valid), 128'(0));
    chk("midreset_key_ready", 128'(bus.key_ready), 128'(1));
    chk("midreset_rk_out", bus.rk_out, 128'h0);
    chk("midreset_rk_round", 128'(bus.rk_round), 128'(0));
    step();
    chk("midreset_no_valid", 128'(bus.rk_valid), 128'(0));
    load_key(KEY_A);
    run_rounds(10, 1, -1, -1);

    // restart from DONE
    bus.rk_restart = 1'b1;
    cycle          = 0;
    step();
    bus.rk_restart = 1'b0;
    run_rounds(10, 2, -1, -1);

    // load and restart together: load wins
    bus.key_in     = KEY_B;
    bus.key_load   = 1'b1;
    bus.rk_restart = 1'b1;
    step();
    bus.key_load   = 1'b0;
    bus.rk_restart = 1'b0;
    chk("prio_valid", 128'(bus.rk_valid), 128'(1));
    chk("prio_round", 128'(bus.rk_round), 128'(0));
    chk("prio_rk_out", bus.rk_out, KEY_B);
    chk("prio_exp_key_out", bus.exp_key_out, KEY_B);
    chk("prio_key_ready", 128'(bus.key_ready), 128'(0));
    chk("prio_state", 128'(state_dbg), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
